// File: rtl/frogger_pkg.sv
// Shared types for the frog movement controller: hop directions, HID
// keycodes, the registered key record and the hop FSM states.
package frogger_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOP  = 1'b1
    } state_t;

    // HID usage codes for WASD and the arrow cluster
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;

    // Decoded key: a direction plus whether the code meant a direction at all
    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_t;

    function automatic key_t decode_key(input logic [7:0] code);
        key_t k;
        k.valid = 1'b1;
        k.dir   = UP;
        case (code)
            KEY_W, KEY_UP:     k.dir = UP;
            KEY_S, KEY_DOWN:   k.dir = DOWN;
            KEY_A, KEY_LEFT:   k.dir = LEFT;
            KEY_D, KEY_RIGHT:  k.dir = RIGHT;
            default:           k.valid = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/frog_move_ctrl_if.sv
// Keyboard/frame inputs and frog position outputs of the movement controller.
// The master side drives the keyboard and frame signals; the slave is the
// controller itself.
interface frog_move_ctrl_if;
    logic [7:0] keycode;
    logic       frame_tick;
    logic       enable;
    logic       respawn;
    logic [3:0] frog_col;
    logic [3:0] frog_row;
    logic [1:0] hop_dir;
    logic       hopping;
    logic       move_pulse;

    modport master (
        output keycode, frame_tick, enable, respawn,
        input  frog_col, frog_row, hop_dir, hopping, move_pulse
    );

    modport slave (
        input  keycode, frame_tick, enable, respawn,
        output frog_col, frog_row, hop_dir, hopping, move_pulse
    );
endinterface

// File: rtl/frog_move_ctrl_key_repeat.sv
// Keycode decode, press-edge detection and hold-to-repeat pacing.
// Emits a one-cycle request (press or auto-repeat) carrying the held direction.
module key_repeat
    import frogger_pkg::*;
#(
    parameter int REPEAT_DELAY  = 15,
    parameter int REPEAT_PERIOD = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    input  logic       clear,
    output logic       req_valid,
    output dir_t       req_dir
);

    localparam int            CW      = $clog2(REPEAT_DELAY + 1);
    // The tick that takes the count from DELAY-1 to DELAY fires the repeat
    localparam logic [CW-1:0] FIRE_AT = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RELOAD  = CW'(REPEAT_DELAY - REPEAT_PERIOD);

    key_t          key_q, key_d;
    key_t          prev_q, prev_d;
    logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          press;
    logic          repeat_fire;

    // Press detection and repeat counter next-state
    always_comb begin
        key_d       = decode_key(keycode);
        prev_d      = key_q;
        press       = key_q.valid && (!prev_q.valid || (key_q.dir != prev_q.dir));
        repeat_fire = 1'b0;
        rpt_cnt_d   = rpt_cnt_q;
        if (clear || press || !key_q.valid) begin
            // A press also swallows a coincident frame tick
            rpt_cnt_d = '0;
        end else if (frame_tick) begin
            if (rpt_cnt_q == FIRE_AT) begin
                repeat_fire = 1'b1;
                rpt_cnt_d   = RELOAD;
            end else begin
                rpt_cnt_d = rpt_cnt_q + CW'(1);
            end
        end
        req_valid = press || repeat_fire;
        req_dir   = key_q.dir;
    end

    // Key history and repeat counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q     <= '0;
            prev_q    <= '0;
            rpt_cnt_q <= '0;
        end else begin
            key_q     <= key_d;
            prev_q    <= prev_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

endmodule

// File: rtl/frog_move_ctrl.sv
// Frog movement controller: turns keyboard requests into grid-bounded hops,
// buffering one request while a hop is locked for HOP_FRAMES frames.
module frog_move_ctrl
    import frogger_pkg::*;
#(
    parameter int COLS          = 13,
    parameter int ROWS          = 13,
    parameter int START_COL     = 6,
    parameter int START_ROW     = 12,
    parameter int HOP_FRAMES    = 4,
    parameter int REPEAT_DELAY  = 15,
    parameter int REPEAT_PERIOD = 6
) (
    input  logic            clk,
    input  logic            reset,
    frog_move_ctrl_if.slave bus
);

    localparam int         HW      = $clog2(HOP_FRAMES + 1);
    localparam logic [3:0] COL_MAX = 4'(COLS - 1);
    localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);
    localparam logic [3:0] COL_0   = 4'(START_COL);
    localparam logic [3:0] ROW_0   = 4'(START_ROW);

    state_t        state_q, state_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    row_q, row_d;
    dir_t          hop_dir_q, hop_dir_d;
    logic          hopping_q, hopping_d;
    logic          pulse_q, pulse_d;
    logic [HW-1:0] hop_cnt_q, hop_cnt_d;
    logic          pend_valid_q, pend_valid_d;
    dir_t          pend_dir_q, pend_dir_d;

    logic          req_valid;
    dir_t          req_dir;
    logic          consume;
    logic          in_bounds;
    logic [3:0]    tgt_col;
    logic [3:0]    tgt_row;

    key_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_key_repeat (
        .clk        (clk),
        .reset      (reset),
        .keycode    (bus.keycode),
        .frame_tick (bus.frame_tick),
        .clear      (bus.respawn),
        .req_valid  (req_valid),
        .req_dir    (req_dir)
    );

    // Target of the pending move; bounds are checked on the current position
    // so the 4-bit coordinates never wrap
    always_comb begin
        tgt_col   = col_q;
        tgt_row   = row_q;
        in_bounds = 1'b0;
        case (pend_dir_q)
            UP: begin
                in_bounds = (row_q != 4'd0);
                tgt_row   = row_q - 4'd1;
            end
            DOWN: begin
                in_bounds = (row_q < ROW_MAX);
                tgt_row   = row_q + 4'd1;
            end
            LEFT: begin
                in_bounds = (col_q != 4'd0);
                tgt_col   = col_q - 4'd1;
            end
            default: begin
                in_bounds = (col_q < COL_MAX);
                tgt_col   = col_q + 4'd1;
            end
        endcase
    end

    // Hop FSM, position tracking and pending-buffer next-state
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        hop_dir_d    = hop_dir_q;
        hopping_d    = hopping_q;
        pulse_d      = 1'b0;
        hop_cnt_d    = hop_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        consume      = (state_q == ST_IDLE) && pend_valid_q && bus.enable;

        if (bus.respawn) begin
            // Respawn outranks any request arriving this cycle
            state_d      = ST_IDLE;
            col_d        = COL_0;
            row_d        = ROW_0;
            hop_dir_d    = UP;
            hopping_d    = 1'b0;
            hop_cnt_d    = '0;
            pend_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Out-of-bounds requests are consumed silently
                    if (consume && in_bounds) begin
                        col_d     = tgt_col;
                        row_d     = tgt_row;
                        hop_dir_d = pend_dir_q;
                        pulse_d   = 1'b1;
                        hop_cnt_d = HW'(HOP_FRAMES);
                        hopping_d = 1'b1;
                        state_d   = ST_HOP;
                    end
                end
                default: begin
                    if (bus.frame_tick) begin
                        if (hop_cnt_q <= HW'(1)) begin
                            hop_cnt_d = '0;
                            hopping_d = 1'b0;
                            state_d   = ST_IDLE;
                        end else begin
                            hop_cnt_d = hop_cnt_q - HW'(1);
                        end
                    end
                end
            endcase

            // Newest request wins; a disabled game holds nothing in reserve
            if (!bus.enable) begin
                pend_valid_d = 1'b0;
            end else if (req_valid) begin
                pend_valid_d = 1'b1;
                pend_dir_d   = req_dir;
            end else if (consume) begin
                pend_valid_d = 1'b0;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            col_q        <= COL_0;
            row_q        <= ROW_0;
            hop_dir_q    <= UP;
            hopping_q    <= 1'b0;
            pulse_q      <= 1'b0;
            hop_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= UP;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hop_dir_q    <= hop_dir_d;
            hopping_q    <= hopping_d;
            pulse_q      <= pulse_d;
            hop_cnt_q    <= hop_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
        end
    end

    assign bus.frog_col   = col_q;
    assign bus.frog_row   = row_q;
    assign bus.hop_dir    = hop_dir_q;
    assign bus.hopping    = hopping_q;
    assign bus.move_pulse = pulse_q;

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Bench for frog_move_ctrl: directed scenarios with literal expectations,
// then randomized key/enable/respawn/reset traffic, all checked every cycle
// against a frame-counting reference model.
module tb_frog_move_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    frog_move_ctrl_if bus();

    frog_move_ctrl #(
        .COLS(13), .ROWS(13), .START_COL(6), .START_ROW(12),
        .HOP_FRAMES(4), .REPEAT_DELAY(15), .REPEAT_PERIOD(6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;
    int base   = 0;
    logic cur_en = 1'b1;

    // ---------------- reference model ----------------
    // Directions: -1 none, 0 up, 1 down, 2 left, 3 right.
    // m_held counts frames since the press; repeats fire at 15, 21, 27, ...
    int m_ok = 0;
    int m_key = -1, m_prev = -1, m_held = 0, m_pend = -1;
    int m_col = 6, m_row = 12, m_dir = 0, m_hop = 0, m_pulse = 0;
    int t_press, t_held, t_req, t_consume, t_nc, t_nr;

    function automatic int dir_of(input logic [7:0] c);
        case (c)
            8'h1A, 8'h52: return 0;
            8'h16, 8'h51: return 1;
            8'h04, 8'h50: return 2;
            8'h07, 8'h4F: return 3;
            default:      return -1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ok = 1; m_key = -1; m_prev = -1; m_held = 0; m_pend = -1;
            m_col = 6; m_row = 12; m_dir = 0; m_hop = 0; m_pulse = 0;
        end else begin
            t_press = (m_key >= 0 && m_key != m_prev) ? 1 : 0;
            t_held  = m_held;
            t_req   = -1;
            if (m_key < 0 || t_press == 1) begin
                t_held = 0;
            end else if (bus.frame_tick) begin
                t_held = m_held + 1;
                if (t_held >= 15 && (t_held - 15) % 6 == 0) t_req = m_key;
            end
            if (t_press == 1) t_req = m_key;
            m_pulse = 0;
            if (bus.respawn) begin
                m_col = 6; m_row = 12; m_dir = 0; m_hop = 0; m_pend = -1; m_held = 0;
            end else begin
                t_consume = (m_hop == 0 && m_pend >= 0 && bus.enable) ? 1 : 0;
                if (m_hop > 0) begin
                    if (bus.frame_tick) m_hop = m_hop - 1;
                end else if (t_consume == 1) begin
                    t_nc = m_col + ((m_pend == 3) ? 1 : (m_pend == 2) ? -1 : 0);
                    t_nr = m_row + ((m_pend == 1) ? 1 : (m_pend == 0) ? -1 : 0);
                    if (t_nc >= 0 && t_nc <= 12 && t_nr >= 0 && t_nr <= 12) begin
                        m_col = t_nc; m_row = t_nr; m_dir = m_pend;
                        m_pulse = 1; m_hop = 4;
                    end
                end
                if (!bus.enable)        m_pend = -1;
                else if (t_req >= 0)    m_pend = t_req;
                else if (t_consume == 1) m_pend = -1;
                m_held = t_held;
            end
            m_prev = m_key;
            m_key  = dir_of(bus.keycode);
        end
    end

    // ---------------- stimulus / compare ----------------
    // One cycle: drive inputs, pass the active edge, then compare every output
    // against the model on the falling edge.
    task automatic step(input logic [7:0] kc, input logic en, input logic rsp,
                        input logic rst, input logic tk);
        bus.keycode    = kc;
        bus.enable     = en;
        bus.respawn    = rsp;
        bus.frame_tick = tk;
        reset          = rst;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (bus.move_pulse === 1'b1) pulses++;
        if (m_ok != 0) begin
            checks++;
            if (bus.frog_col !== 4'(m_col) || bus.frog_row !== 4'(m_row) ||
                bus.hop_dir !== 2'(m_dir) || bus.hopping !== (m_hop > 0) ||
                bus.move_pulse !== (m_pulse != 0)) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL cycle_cmp cyc=%0d got col=%0d row=%0d dir=%0d hop=%0b pulse=%0b want col=%0d row=%0d dir=%0d hop=%0b pulse=%0b",
                             cyc, bus.frog_col, bus.frog_row, bus.hop_dir, bus.hopping, bus.move_pulse,
                             m_col, m_row, m_dir, (m_hop > 0), (m_pulse != 0));
            end
        end
    endtask

    task automatic run(input logic [7:0] kc, input int n);
        for (int i = 0; i < n; i++) step(kc, cur_en, 1'b0, 1'b0, (cyc % 4) == 0);
    endtask

    task automatic do_respawn();
        step(8'h00, cur_en, 1'b1, 1'b0, (cyc % 4) == 0);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        logic [7:0] codes [10];
        logic [7:0] kc;
        int hold;
        codes = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h52, 8'h51, 8'h50, 8'h4F, 8'h00, 8'h33};

        // Reset
        step(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("reset_col", bus.frog_col, 6);
        chk("reset_row", bus.frog_row, 12);
        chk("reset_dir", bus.hop_dir, 0);
        chk("reset_hopping", bus.hopping, 0);
        chk("reset_pulse", bus.move_pulse, 0);

        // Single press: pulse appears after the third edge from the first sample
        base = pulses;
        run(8'h1A, 2);
        chk("press_no_early_pulse", pulses - base, 0);
        run(8'h1A, 1);
        chk("press_latency_pulse", bus.move_pulse, 1);
        chk("press_latency_hopping", bus.hopping, 1);
        run(8'h00, 30);
        chk("single_pulses", pulses - base, 1);
        chk("single_row", bus.frog_row, 11);
        chk("single_dir", bus.hop_dir, 0);

        // Hold right: press + repeats at 15,21,27,33,39; frame 45 hits the edge
        base = pulses;
        run(8'h07, 46 * 4);
        run(8'h00, 30);
        chk("repeat_pulses", pulses - base, 6);
        chk("repeat_col", bus.frog_col, 12);
        chk("repeat_dir", bus.hop_dir, 3);

        // Buffering: latest request during a hop wins
        do_respawn();
        base = pulses;
        run(8'h1A, 2); run(8'h00, 2);
        run(8'h16, 2); run(8'h00, 2);
        run(8'h04, 2); run(8'h00, 30);
        chk("buffer_pulses", pulses - base, 2);
        chk("buffer_col", bus.frog_col, 5);
        chk("buffer_row", bus.frog_row, 11);
        chk("buffer_dir", bus.hop_dir, 2);

        // Top boundary
        for (int i = 0; i < 11; i++) begin
            run(8'h1A, 2); run(8'h00, 22);
        end
        chk("climb_row", bus.frog_row, 0);
        base = pulses;
        run(8'h1A, 2); run(8'h00, 22);
        chk("top_edge_pulses", pulses - base, 0);
        chk("top_edge_row", bus.frog_row, 0);

        // Bottom boundary
        do_respawn();
        base = pulses;
        run(8'h16, 2); run(8'h00, 22);
        chk("bottom_edge_pulses", pulses - base, 0);
        chk("bottom_edge_row", bus.frog_row, 12);

        // Respawn in the press cycle discards the press
        run(8'h1A, 2); run(8'h00, 22);
        base = pulses;
        step(8'h1A, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'h1A, 1'b1, 1'b1, 1'b0, 1'b0);
        run(8'h00, 22);
        chk("respawn_pulses", pulses - base, 0);
        chk("respawn_col", bus.frog_col, 6);
        chk("respawn_row", bus.frog_row, 12);

        // Disabled game drops presses; re-enabling does not resurrect them
        cur_en = 1'b0;
        base = pulses;
        run(8'h1A, 2); run(8'h00, 10);
        cur_en = 1'b1;
        run(8'h00, 22);
        chk("enable_pulses", pulses - base, 0);
        chk("enable_row", bus.frog_row, 12);

        // Reset two frames into a hop with a buffered move
        run(8'h1A, 3);
        run(8'h00, 8);
        run(8'h04, 2);
        step(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("midhop_reset_hopping", bus.hopping, 0);
        chk("midhop_reset_col", bus.frog_col, 6);
        chk("midhop_reset_row", bus.frog_row, 12);
        base = pulses;
        run(8'h00, 30);
        chk("midhop_reset_pulses", pulses - base, 0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            kc   = codes[$urandom_range(0, 9)];
            hold = $urandom_range(1, 40);
            for (int i = 0; i < hold; i++)
                step(kc, ($urandom_range(0, 15) != 0), ($urandom_range(0, 99) == 0),
                     ($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
